// File: rtl/mem_seq_arbiter.sv
// Sequencing arbiter: serializes fetch and load/store requests onto a single byte-wide
// memory port, reassembling read bytes little-endian.
module mem_seq_arbiter #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              busy
);

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StDone
    } state_e;

    state_e            r_state;
    state_e            w_state_next;

    logic              r_port_ls;
    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_n;
    logic [2:0]        r_k;
    logic [31:0]       r_wdata;
    logic [31:0]       r_asm;
    logic [31:0]       r_if_inst;
    logic [31:0]       r_ls_rdata;

    logic              w_grant_ls;
    logic              w_grant_if;
    logic [2:0]        w_n_ls;
    logic              w_rd_last;
    logic              w_wr_last;
    logic [31:0]       w_asm_next;
    logic [ADDR_W-1:0] w_k_ext;

    // Load/store has fixed priority over fetch.
    assign w_grant_ls = (r_state == StIdle) && ls_req;
    assign w_grant_if = (r_state == StIdle) && !ls_req && if_req;

    always_comb begin
        w_n_ls = 3'd4;
        case (ls_size)
            2'b00:   w_n_ls = 3'd1;
            2'b01:   w_n_ls = 3'd2;
            default: w_n_ls = 3'd4;
        endcase
    end

    // RD spends one extra cycle (k == n) to collect the last byte.
    assign w_rd_last = (r_k == r_n);
    assign w_wr_last = (r_k == (r_n - 3'd1));
    assign w_k_ext   = {{(ADDR_W-3){1'b0}}, r_k};

    // Data returned in cycle k belongs to the address issued in cycle k-1.
    always_comb begin
        w_asm_next = r_asm;
        if (r_state == StRd) begin
            case (r_k)
                3'd1:    w_asm_next[7:0]   = mem_din;
                3'd2:    w_asm_next[15:8]  = mem_din;
                3'd3:    w_asm_next[23:16] = mem_din;
                3'd4:    w_asm_next[31:24] = mem_din;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_grant_ls) begin
                    w_state_next = ls_we ? StWr : StRd;
                end else if (w_grant_if) begin
                    w_state_next = StRd;
                end
            end
            StRd: begin
                if (w_rd_last) begin
                    w_state_next = StDone;
                end
            end
            StWr: begin
                if (w_wr_last) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_port_ls  <= 1'b0;
            r_base     <= '0;
            r_n        <= 3'd0;
            r_k        <= 3'd0;
            r_wdata    <= 32'd0;
            r_asm      <= 32'd0;
            r_if_inst  <= 32'd0;
            r_ls_rdata <= 32'd0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                StIdle: begin
                    if (w_grant_ls || w_grant_if) begin
                        r_port_ls <= w_grant_ls;
                        r_base    <= w_grant_ls ? ls_addr : if_addr;
                        r_n       <= w_grant_ls ? w_n_ls : 3'd4;
                        r_wdata   <= w_grant_ls ? ls_wdata : 32'd0;
                        r_k       <= 3'd0;
                        r_asm     <= 32'd0;
                    end
                end
                StRd: begin
                    r_asm <= w_asm_next;
                    r_k   <= r_k + 3'd1;
                    // Publish on the way into DONE so the word is valid alongside the done pulse.
                    if (w_rd_last) begin
                        if (r_port_ls) begin
                            r_ls_rdata <= w_asm_next;
                        end else begin
                            r_if_inst <= w_asm_next;
                        end
                    end
                end
                StWr: begin
                    r_k <= r_k + 3'd1;
                end
                StDone: ;
                default: ;
            endcase
        end
    end

    always_comb begin
        if_done  = 1'b0;
        ls_done  = 1'b0;
        mem_wr   = 1'b0;
        mem_a    = '0;
        mem_dout = 8'd0;
        busy     = (r_state != StIdle);
        unique case (r_state)
            StIdle: ;
            StRd: begin
                if (!w_rd_last) begin
                    mem_a = r_base + w_k_ext;
                end
            end
            StWr: begin
                mem_wr = 1'b1;
                mem_a  = r_base + w_k_ext;
                case (r_k[1:0])
                    2'd0:    mem_dout = r_wdata[7:0];
                    2'd1:    mem_dout = r_wdata[15:8];
                    2'd2:    mem_dout = r_wdata[23:16];
                    default: mem_dout = r_wdata[31:24];
                endcase
            end
            StDone: begin
                if_done = !r_port_ls;
                ls_done = r_port_ls;
            end
            default: ;
        endcase
    end

    assign if_inst  = r_if_inst;
    assign ls_rdata = r_ls_rdata;

endmodule
